// File: rtl/display_mode_scan_if.sv
// Display mode / scan bus: page data, buttons and setup handshake in, 7-segment scan out.
interface display_mode_scan_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned NUM_MODES  = 5
);
  localparam int unsigned MW = $clog2(NUM_MODES);

  logic [NUM_MODES*NUM_DIGITS*4-1:0] page_digits;
  logic [NUM_MODES*NUM_DIGITS-1:0]   page_dp;
  logic                              nMode;
  logic                              nTrip;
  logic                              ready;
  logic [3:0]                        bcd_out;
  logic [NUM_DIGITS-1:0]             nDigit;
  logic                              DP;
  logic                              ws_en;
  logic [MW-1:0]                     mode_idx;

  modport master (
    output page_digits, page_dp, nMode, nTrip, ready,
    input  bcd_out, nDigit, DP, ws_en, mode_idx
  );

  modport slave (
    input  page_digits, page_dp, nMode, nTrip, ready,
    output bcd_out, nDigit, DP, ws_en, mode_idx
  );
endinterface

// File: rtl/display_mode_scan.sv
// Display mode controller: page select via nMode/nTrip buttons, setup handshake, power-on
// lamp test and time-multiplexed 7-segment scan with tear-free frame latching.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros (digits 1..NUM_DIGITS-2).
module display_mode_scan #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned NUM_MODES   = 5,
  parameter int unsigned SCAN_DIV    = 1,
  parameter int unsigned LAMP_CYCLES = 16,
  parameter logic [3:0]  BLANK_CODE  = 4'd15
) (
  input logic                clock,
  input logic                Rst,
  display_mode_scan_if.slave bus
);

  localparam int unsigned DW       = $clog2(NUM_DIGITS);
  localparam int unsigned MW       = $clog2(NUM_MODES);
  localparam int unsigned PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned LW       = (LAMP_CYCLES > 2) ? $clog2(LAMP_CYCLES) : 1;
  localparam int unsigned LampLast = (LAMP_CYCLES > 0) ? LAMP_CYCLES - 1 : 0;

  localparam logic [DW-1:0] LastDigit  = DW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PresLast   = PW'(SCAN_DIV - 1);
  localparam logic [LW-1:0] LampLastL  = LW'(LampLast);
  localparam logic [MW-1:0] SetupMode  = MW'(NUM_MODES - 1);
  localparam logic [MW-1:0] LastNormal = MW'(NUM_MODES - 2);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LzbEn = 1'b1;
`else
  localparam bit LzbEn = 1'b0;
`endif

  typedef enum logic [0:0] {StLamp, StScan} state_e;

  state_e state_q, state_d;
  logic [LW-1:0] lamp_cnt_q, lamp_cnt_d;
  logic [PW-1:0] pres_q, pres_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [MW-1:0] mode_q, mode_d;
  logic          ws_en_q, ws_en_d;
  logic [1:0]    mode_sync_q, trip_sync_q;
  logic          mode_dly_q, trip_dly_q;
  logic [NUM_DIGITS-1:0][3:0] frame_dig_q, frame_dig_d;
  logic [NUM_DIGITS-1:0]      frame_dp_q, frame_dp_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] ndigit_q, ndigit_d;
  logic                  dp_q, dp_d;

  logic [NUM_MODES-1:0][NUM_DIGITS-1:0][3:0] pages;
  logic [NUM_MODES-1:0][NUM_DIGITS-1:0]      dps;
  logic mode_s, trip_s, mode_fall, trip_fall;
  logic restart, latch, lz_lead;

  assign pages = bus.page_digits;
  assign dps   = bus.page_dp;

  assign mode_s    = mode_sync_q[1];
  assign trip_s    = trip_sync_q[1];
  assign mode_fall = mode_dly_q & ~mode_s;
  assign trip_fall = trip_dly_q & ~trip_s;

  // Button synchronisers plus edge-detect delay; idle-high so reset never fakes a press.
  always_ff @(posedge clock) begin
    if (Rst) begin
      mode_sync_q <= 2'b11;
      trip_sync_q <= 2'b11;
      mode_dly_q  <= 1'b1;
      trip_dly_q  <= 1'b1;
    end else begin
      mode_sync_q <= {mode_sync_q[0], bus.nMode};
      trip_sync_q <= {trip_sync_q[0], bus.nTrip};
      mode_dly_q  <= mode_s;
      trip_dly_q  <= trip_s;
    end
  end

  // Mode events, lamp/scan sequencing, frame latch and next registered outputs.
  always_comb begin
    state_d     = state_q;
    lamp_cnt_d  = lamp_cnt_q;
    pres_d      = pres_q;
    dig_d       = dig_q;
    mode_d      = mode_q;
    ws_en_d     = ws_en_q;
    frame_dig_d = frame_dig_q;
    frame_dp_d  = frame_dp_q;
    bcd_d       = bcd_q;
    ndigit_d    = ndigit_q;
    dp_d        = dp_q;
    restart     = 1'b0;
    latch       = 1'b0;
    lz_lead     = 1'b1;

    if (!mode_s && !trip_s && (mode_fall || trip_fall)) begin
      mode_d  = SetupMode;
      ws_en_d = 1'b1;
      restart = 1'b1;
    end else if (ws_en_q && bus.ready) begin
      mode_d  = '0;
      ws_en_d = 1'b0;
      restart = 1'b1;
    end else if (!ws_en_q && mode_fall && trip_s) begin
      mode_d  = (mode_q == LastNormal) ? '0 : mode_q + 1'b1;
      restart = 1'b1;
    end

    case (state_q)
      StLamp: begin
        // Events during lamp only move mode/ws_en; scanning starts when lamp expires.
        if (lamp_cnt_q == LampLastL) begin
          state_d = StScan;
          pres_d  = '0;
          dig_d   = '0;
          latch   = 1'b1;
        end else begin
          lamp_cnt_d = lamp_cnt_q + 1'b1;
        end
      end
      StScan: begin
        if (restart) begin
          pres_d = '0;
          dig_d  = '0;
          latch  = 1'b1;
        end else if (pres_q == PresLast) begin
          pres_d = '0;
          dig_d  = (dig_q == LastDigit) ? '0 : dig_q + 1'b1;
          latch  = (dig_q == LastDigit);
        end else begin
          pres_d = pres_q + 1'b1;
        end
      end
      default: state_d = StLamp;
    endcase

    // Whole page is captured at frame start so mid-frame input changes cannot tear.
    if (latch) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        frame_dig_d[i] = pages[mode_d][i];
        frame_dp_d[i]  = dps[mode_d][i];
        if (LzbEn && !ws_en_d && i >= 1 && i <= NUM_DIGITS - 2) begin
          if (lz_lead && pages[mode_d][i] == 4'd0) begin
            frame_dig_d[i] = BLANK_CODE;
            frame_dp_d[i]  = 1'b0;
          end else begin
            lz_lead = 1'b0;
          end
        end
      end
    end

    if (state_d == StScan) begin
      ndigit_d                    = '1;
      ndigit_d[LastDigit - dig_d] = 1'b0;
      bcd_d                       = frame_dig_d[dig_d];
      dp_d                        = frame_dp_d[dig_d];
    end else begin
      ndigit_d = '0;
      bcd_d    = 4'd8;
      dp_d     = 1'b1;
    end
  end

  // State, frame and output registers; reset enters the lamp test.
  always_ff @(posedge clock) begin
    if (Rst) begin
      state_q     <= StLamp;
      lamp_cnt_q  <= '0;
      pres_q      <= '0;
      dig_q       <= '0;
      mode_q      <= '0;
      ws_en_q     <= 1'b0;
      frame_dig_q <= '0;
      frame_dp_q  <= '0;
      bcd_q       <= 4'd8;
      ndigit_q    <= '0;
      dp_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      lamp_cnt_q  <= lamp_cnt_d;
      pres_q      <= pres_d;
      dig_q       <= dig_d;
      mode_q      <= mode_d;
      ws_en_q     <= ws_en_d;
      frame_dig_q <= frame_dig_d;
      frame_dp_q  <= frame_dp_d;
      bcd_q       <= bcd_d;
      ndigit_q    <= ndigit_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.bcd_out  = bcd_q;
  assign bus.nDigit   = ndigit_q;
  assign bus.DP       = dp_q;
  assign bus.ws_en    = ws_en_q;
  assign bus.mode_idx = mode_q;

endmodule

// File: tb/tb_display_mode_scan.sv
// Bench for display_mode_scan: directed sequence with random page data, checked against a
// frame-level model (digit = page value, slot = time/SCAN_DIV mod NUM_DIGITS).
module tb_display_mode_scan;
  localparam int N  = 4;
  localparam int NM = 5;
  localparam int SD = 2;
  localparam int LC = 4;
  localparam int FL = N * SD;

  logic clk = 1'b0;
  logic rst;

  display_mode_scan_if #(.NUM_DIGITS(N), .NUM_MODES(NM)) bus ();

  display_mode_scan #(
    .NUM_DIGITS (N),
    .NUM_MODES  (NM),
    .SCAN_DIV   (SD),
    .LAMP_CYCLES(LC),
    .BLANK_CODE (4'd15)
  ) dut (
    .clock(clk),
    .Rst  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_mode = 0;
  logic exp_ws = 1'b0;
  logic [3:0] exp_dig [N];
  logic       exp_dp  [N];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_digit(input int m, input int d, input logic [3:0] v);
    bus.page_digits[(m*N+d)*4 +: 4] = v;
  endtask

  // Expected frame for page m, straight from the page data and the blanking rule.
  function automatic void load_exp(input int m);
`ifdef LEADING_ZERO_BLANK_EN
    bit lead = 1'b1;
`endif
    for (int d = 0; d < N; d++) begin
      logic [3:0] v = bus.page_digits[(m*N+d)*4 +: 4];
      logic       p = bus.page_dp[m*N+d];
`ifdef LEADING_ZERO_BLANK_EN
      if (m != NM - 1 && d >= 1 && d <= N - 2) begin
        if (lead && v == 4'd0) begin
          v = 4'd15;
          p = 1'b0;
        end else begin
          lead = 1'b0;
        end
      end
`endif
      exp_dig[d] = v;
      exp_dp[d]  = p;
    end
  endfunction

  task automatic check_lamp(input string tag);
    chk({tag, "_ndig"}, 32'(bus.nDigit), 32'(0));
    chk({tag, "_bcd"}, 32'(bus.bcd_out), 32'(8));
    chk({tag, "_dp"}, 32'(bus.DP), 32'(1));
  endtask

  // Called on the negedge right after a scan restart (t=0); frames reload every FL clocks.
  task automatic check_scan(input string tag, input int cycles, input int poke_t,
                            input logic [3:0] poke_v);
    for (int t = 0; t < cycles; t++) begin
      int d = (t / SD) % N;
      logic [N-1:0] e = '1;
      e[N-1-d] = 1'b0;
      if (t % FL == 0) load_exp(exp_mode);
      chk({tag, "_ndig"}, 32'(bus.nDigit), 32'(e));
      chk({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp_dig[d]));
      chk({tag, "_dp"}, 32'(bus.DP), 32'(exp_dp[d]));
      chk({tag, "_mode"}, 32'(bus.mode_idx), 32'(exp_mode));
      chk({tag, "_ws"}, 32'(bus.ws_en), 32'(exp_ws));
      if (t == poke_t) set_digit(0, 3, poke_v);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] old_v;
    rst       = 1'b1;
    bus.nMode = 1'b1;
    bus.nTrip = 1'b1;
    bus.ready = 1'b0;
    for (int m = 0; m < NM; m++) begin
      for (int d = 0; d < N; d++) begin
        set_digit(m, d, 4'($urandom_range(0, 15)));
        bus.page_dp[m*N+d] = 1'($urandom_range(0, 1));
      end
    end
    set_digit(0, 0, 4'd10); set_digit(0, 1, 4'd1); set_digit(0, 2, 4'd2); set_digit(0, 3, 4'd3);
    bus.page_dp[3:0] = 4'b0100;
    set_digit(1, 0, 4'd10); set_digit(1, 1, 4'd0); set_digit(1, 2, 4'd0); set_digit(1, 3, 4'd5);
    set_digit(2, 0, 4'd10); set_digit(2, 1, 4'd0); set_digit(2, 2, 4'd7); set_digit(2, 3, 4'd0);

    // Reset and lamp test, then first scan of page 0.
    @(negedge clk);
    tick();
    rst = 1'b0;
    for (int i = 0; i < LC; i++) begin
      check_lamp("lamp");
      chk("lamp_mode", 32'(bus.mode_idx), 32'(0));
      chk("lamp_ws", 32'(bus.ws_en), 32'(0));
      tick();
    end
    check_scan("scan0", 2 * FL, -1, 4'd0);

    // Four single nMode presses, random spacing; wrap 3 -> 0.
    for (int k = 1; k <= 4; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      bus.nMode = 1'b0;
      tick();
      tick();
      chk("press_early", 32'(bus.mode_idx), 32'((k - 1) % (NM - 1)));
      tick();
      exp_mode  = k % (NM - 1);
      bus.nMode = 1'b1;
      check_scan("press", FL + 2, -1, 4'd0);
    end

    // Combo enters setup; nMode ignored in setup; ready exits.
    bus.nMode = 1'b0;
    bus.nTrip = 1'b0;
    tick();
    tick();
    chk("combo_early", 32'(bus.ws_en), 32'(0));
    tick();
    exp_mode  = NM - 1;
    exp_ws    = 1'b1;
    bus.nMode = 1'b1;
    bus.nTrip = 1'b1;
    check_scan("combo", FL + 2, -1, 4'd0);
    bus.nMode = 1'b0;
    repeat (4) tick();
    chk("setup_ign_mode", 32'(bus.mode_idx), 32'(NM - 1));
    chk("setup_ign_ws", 32'(bus.ws_en), 32'(1));
    bus.nMode = 1'b1;
    repeat (3) tick();
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    exp_mode  = 0;
    exp_ws    = 1'b0;
    // Tear test: digit 3 of page 0 changes while d=1.
    old_v = bus.page_digits[3*4 +: 4];
    check_scan("tear", 2 * FL, SD, old_v ^ 4'h5);

    // ready outside setup and nTrip alone are ignored.
    bus.ready = 1'b1;
    repeat (3) tick();
    bus.ready = 1'b0;
    chk("ready_ign", 32'(bus.mode_idx), 32'(0));
    bus.nTrip = 1'b0;
    repeat (4) tick();
    chk("trip_ign_mode", 32'(bus.mode_idx), 32'(0));
    chk("trip_ign_ws", 32'(bus.ws_en), 32'(0));
    bus.nTrip = 1'b1;
    repeat (3) tick();

    // Reset in setup at d=2, then a press during lamp.
    bus.nMode = 1'b0;
    bus.nTrip = 1'b0;
    repeat (3) tick();
    bus.nMode = 1'b1;
    bus.nTrip = 1'b1;
    chk("pre_rst_ws", 32'(bus.ws_en), 32'(1));
    repeat (2 * SD) tick();
    chk("pre_rst_ndig", 32'(bus.nDigit), 32'(4'b1101));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_lamp("rst_lamp");
    chk("rst_ws", 32'(bus.ws_en), 32'(0));
    chk("rst_mode", 32'(bus.mode_idx), 32'(0));
    bus.nMode = 1'b0;
    tick();
    check_lamp("lamp_press1");
    tick();
    check_lamp("lamp_press2");
    tick();
    check_lamp("lamp_press3");
    chk("lamp_press_mode", 32'(bus.mode_idx), 32'(1));
    bus.nMode = 1'b1;
    tick();
    exp_mode = 1;
    check_scan("post_rst", 2 * FL, -1, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/display_mode_scan.md
Name: display_mode_scan

Overview:
- Parametrised successor to the cycle-computer display mode controller.
- Selects one of NUM_MODES display pages and time-multiplexes its NUM_DIGITS BCD digits onto a shared common-cathode 7-segment driver.
- Debounce-free edge detection on the nMode/nTrip buttons.
- Includes a configurable scan prescaler, tear-free frame latching, a power-on lamp test, and a setup mode with ready handshake (drives the wheel-size setup block).

Parameters:
NUM_DIGITS, 4, digits per page; digit 0 is the leftmost (mode-letter) position; minimum 2
NUM_MODES, 5, pages; modes 0..NUM_MODES-2 are normal, mode NUM_MODES-1 is setup; minimum 2
SCAN_DIV, 1, clocks per digit slot; minimum 1
LAMP_CYCLES, 16, clocks of all-segments lamp test after reset; 0 disables it
BLANK_CODE, 15, bcd_out value the decoder renders blank

Ports:
clock  in  1  system clock
Rst  in  1  synchronous active-high reset
page_digits  in  NUM_MODES*NUM_DIGITS*4  BCD digits; mode m, digit d at bits [(m*NUM_DIGITS+d)*4 +: 4]
page_dp  in  NUM_MODES*NUM_DIGITS  decimal-point enables; mode m, digit d at bit m*NUM_DIGITS+d
nMode  in  1  mode button, active low, asynchronous
nTrip  in  1  trip button, active low, asynchronous
ready  in  1  setup block done, level, synchronous
bcd_out  out  4  digit code to the 7-segment decoder
nDigit  out  NUM_DIGITS  digit enables, active low, one-hot-low during scan
DP  out  1  decimal point for the active digit
ws_en  out  1  setup enable, high while in setup mode
mode_idx  out  $clog2(NUM_MODES)  current page

Behaviour:
- Reset (Rst high at a clock edge):
  - mode_idx=0, ws_en=0.
  - Lamp state entered: nDigit=all 0, bcd_out=8, DP=1.
  - Prescaler, digit index and synchronisers cleared; synchroniser flops cleared to 1.
- Lamp state:
  - Holds for LAMP_CYCLES clocks.
  - Button edges arriving during lamp are still acted on (mode_idx/ws_en update), but scanning starts only after lamp ends.
  - With LAMP_CYCLES=0, scanning starts on the first clock after reset.
- Button synchronisation:
  - nMode and nTrip each pass through a 2-flop synchroniser, giving nMode_s and nTrip_s, plus a delay flop for edge detection.
  - A press is a 1->0 transition of the synchronised signal.
  - An input falling 3 clocks before an edge changes mode_idx at that edge, i.e. fixed latency of 3 clocks.
- Mode events, in priority order, evaluated each clock:
  1. Combo: nMode_s=0 and nTrip_s=0, with at least one of them falling this cycle -> mode_idx=NUM_MODES-1, ws_en=1, scan restarts at digit 0. Also valid while already in setup (restarts setup).
  2. In setup with ready=1 -> mode_idx=0, ws_en=0, scan restarts.
  3. Not in setup, nMode press with nTrip_s=1 -> mode_idx=(mode_idx+1) mod (NUM_MODES-1), scan restarts. Wrap from NUM_MODES-2 to 0.
  - nMode presses in setup are ignored.
  - ready outside setup is ignored.
  - nTrip alone is ignored.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1; on terminal count, digit index advances d -> (d+1) mod NUM_DIGITS.
  - Outputs are registered and update on the same edge the index changes:
    - nDigit has bit (NUM_DIGITS-1-d) low and all other bits high, so digit 0 maps to MSB, e.g. 0111 for 4 digits.
    - bcd_out = frame digit d.
    - DP = frame dp d.
- Scan restart:
  - Prescaler cleared, d=0.
  - Outputs show digit 0 of the new mode on the next clock.
- Frame latch:
  - The selected page's NUM_DIGITS digits and dps are copied into an internal frame register whenever d wraps to 0 and on every scan restart.
  - Input changes mid-frame never appear until the next frame (no tearing).
- Reset mid-operation: Rst overrides all events in the same cycle.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: at frame latch, digits 1..NUM_DIGITS-2 that are 0 and preceded only by zero digits (from digit 1 onward) are replaced by BLANK_CODE, with their DP forced to 0.
  - Digit 0 (letter) and the last digit are never blanked.
  - Not applied in setup mode.
- Undefined: digits are shown verbatim.

Test Plan:
1. Reset, LAMP_CYCLES=4 -> nDigit=0000, bcd_out=8, DP=1 for 4 clocks; then with SCAN_DIV=2, mode 0 page {10,1,2,3}, dp {0,0,1,0}: nDigit 0111/1011/1101/1110 each held 2 clocks, bcd_out 10,1,2,3, DP high only on 1101.
2. NUM_MODES=5, four single nMode presses -> mode_idx 1,2,3,0, each 3 clocks after the falling edge; the scan restarts at digit 0 each time.
3. nMode and nTrip fall together -> mode_idx=4, ws_en=1 after 3 clocks; nMode press ignored; ready=1 for 1 clock -> mode_idx=0, ws_en=0 next clock.
4. Change page_digits for digit 3 while d=1 -> old value still shown at d=3; new value shown on the following frame.
5. Rst high while in setup at d=2 -> next clock ws_en=0, mode_idx=0, lamp outputs present.
6. LEADING_ZERO_BLANK_EN defined, page {10,0,0,5} -> bcd_out 10,15,15,5; page {10,0,7,0} -> 10,15,7,0.
